gate_response_checker: RTL and testbench

//  Synthesizable driver and checker for the two-input gate bank (AND/OR/NOT/NAND/NOR/XOR/XNOR/BUF).

---
 rtl/gate_chk_pkg.sv | 30 +++
 rtl/gate_response_checker_if.sv | 36 +++
 rtl/gate_golden.sv | 24 ++
 rtl/gate_response_checker.sv | 193 +++++++++++++++++++
 tb/tb_gate_response_checker.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_chk_pkg.sv
// -----------------------------------------------------------------------------
// gate_chk_pkg
// Shared types and constants for the gate-bank response checker.
//   state_t        : checker FSM states
//   AND_B..BUF_B   : bit positions of each gate output inside dut_out
//   NUM_VEC        : number of input vectors in one sweep ({in1,in2} = 00..11)
// Optional build macro used by the checker: GATE_CHK_STOP_ON_FAIL_EN
// -----------------------------------------------------------------------------
package gate_chk_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int AND_B  = 0;
   localparam int OR_B   = 1;
   localparam int NOT_B  = 2;
   localparam int NAND_B = 3;
   localparam int NOR_B  = 4;
   localparam int XOR_B  = 5;
   localparam int XNOR_B = 6;
   localparam int BUF_B  = 7;

   localparam int NUM_VEC = 4;

endpackage

// File: rtl/gate_response_checker_if.sv
// -----------------------------------------------------------------------------
// gate_response_checker_if
// Bundles the checker's control/status and the gate-bank stimulus/response.
//   start      : 1-cycle run request
//   in1, in2   : stimulus to the gate bank (driven by the checker)
//   dut_out    : 8 gate outputs returned by the gate bank
//   busy, done : run status; pass valid while done
//   err_count  : saturating mismatch count (ERR_W bits)
//   last_mask  : expected ^ sampled at the most recent failing check
// Modports: slave = checker side, master = host / gate-bank side.
// -----------------------------------------------------------------------------
interface gate_response_checker_if #(
   parameter int ERR_W = 4
) ();

   logic             start;
   logic             in1;
   logic             in2;
   logic [7:0]       dut_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [7:0]       last_mask;

   modport slave (
      input  start, dut_out,
      output in1, in2, busy, done, pass, err_count, last_mask
   );

   modport master (
      output start, dut_out,
      input  in1, in2, busy, done, pass, err_count, last_mask
   );

endinterface

// File: rtl/gate_golden.sv
// -----------------------------------------------------------------------------
// gate_golden
// Combinational reference for the two-input gate bank.
//   in1_i, in2_i : stimulus currently applied to the gate bank
//   exp_o        : expected 8-bit response in dut_out bit order
// -----------------------------------------------------------------------------
module gate_golden
   import gate_chk_pkg::*;
(
   input  logic       in1_i,
   input  logic       in2_i,
   output logic [7:0] exp_o
);

   assign exp_o[AND_B]  = in1_i & in2_i;
   assign exp_o[OR_B]   = in1_i | in2_i;
   assign exp_o[NOT_B]  = ~in1_i;
   assign exp_o[NAND_B] = ~(in1_i & in2_i);
   assign exp_o[NOR_B]  = ~(in1_i | in2_i);
   assign exp_o[XOR_B]  = in1_i ^ in2_i;
   assign exp_o[XNOR_B] = ~(in1_i ^ in2_i);
   assign exp_o[BUF_B]  = in1_i;

endmodule

// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
// Drives {in1,in2} through 00,01,10,11 (LOOPS sweeps), waits SETTLE_CYCLES
// clocks after each drive, samples the gate outputs and compares them with
// gate_golden. Mismatching vectors are counted (saturating) and the last
// failing difference mask is kept. All outputs are registered.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : gate_response_checker_if.slave (start, in1/in2, dut_out, status)
// Parameters: SETTLE_CYCLES (>=1), LOOPS (>=1), ERR_W (err_count width).
// Optional macro GATE_CHK_STOP_ON_FAIL_EN: the first failing check ends the
// run immediately, leaving the failing vector on in1/in2.
// -----------------------------------------------------------------------------
module gate_response_checker
   import gate_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   gate_response_checker_if.slave  bus
);

   localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

   // Settle counter counts SETTLE_CYCLES-1 down to 0, giving SETTLE_CYCLES clocks.
   localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
   localparam logic [1:0]        IDX_LAST  = 2'(NUM_VEC - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

   state_t             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [LOOP_W-1:0]  loop_q, loop_d;
   logic [SET_W-1:0]   set_q, set_d;
   logic               in1_q, in1_d;
   logic               in2_q, in2_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [7:0]         mask_q, mask_d;

   logic [7:0]         exp_s;
   logic [7:0]         diff_s;
   logic               mismatch_s;
   logic               stop_s;
   logic               last_s;
   logic [ERR_W-1:0]   err_inc_s;

   gate_golden u_golden (
      .in1_i (in1_q),
      .in2_i (in2_q),
      .exp_o (exp_s)
   );

   assign diff_s = exp_s ^ bus.dut_out;

   // Simulation treats X/Z on dut_out as a mismatch; hardware has no X.
`ifdef SYNTHESIS
   assign mismatch_s = (exp_s != bus.dut_out);
`else
   assign mismatch_s = (exp_s !== bus.dut_out);
`endif

`ifdef GATE_CHK_STOP_ON_FAIL_EN
   assign stop_s = mismatch_s;
`else
   assign stop_s = 1'b0;
`endif

   assign last_s    = (idx_q == IDX_LAST) && (loop_q == LOOP_LAST);
   assign err_inc_s = (err_q == ERR_MAX) ? err_q : (err_q + ERR_W'(1));

   // Next-state and datapath updates for the sweep FSM.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      loop_d  = loop_q;
      set_d   = set_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      mask_d  = mask_q;

      case (state_q)
         IDLE, DONE: begin
            // A new run wipes the previous result; in1/in2 keep their value
            // until the first DRIVE.
            if (bus.start) begin
               state_d = DRIVE;
               idx_d   = 2'd0;
               loop_d  = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               mask_d  = 8'h00;
            end else begin
               state_d = state_q;
            end
         end

         DRIVE: begin
            in1_d   = idx_q[1];
            in2_d   = idx_q[0];
            set_d   = SET_LOAD;
            state_d = SETTLE;
         end

         SETTLE: begin
            if (set_q == '0) begin
               state_d = CHECK;
            end else begin
               set_d = set_q - SET_W'(1);
            end
         end

         CHECK: begin
            if (mismatch_s) begin
               err_d  = err_inc_s;
               mask_d = diff_s;
            end else begin
               err_d  = err_q;
            end

            // start is not looked at here, so a coincident start is dropped.
            if (stop_s || last_s) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_q == '0) && !mismatch_s;
            end else begin
               state_d = DRIVE;
               idx_d   = idx_q + 2'd1;
               if (idx_q == IDX_LAST) begin
                  loop_d = loop_q + LOOP_W'(1);
               end else begin
                  loop_d = loop_q;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         loop_q  <= '0;
         set_q   <= '0;
         in1_q   <= 1'b0;
         in2_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         mask_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         loop_q  <= loop_d;
         set_q   <= set_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
      end
   end

   assign bus.in1       = in1_q;
   assign bus.in2       = in2_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.last_mask = mask_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_response_checker
// Two checker instances: u0 (SETTLE=2, LOOPS=1, ERR_W=4) and
// u1 (SETTLE=1, LOOPS=3, ERR_W=3). Each drives a behavioural gate bank whose
// outputs can be corrupted with stuck-at-0 / stuck-at-1 / invert masks.
// Expected run results are predicted when a run is started, queued, and
// compared when done rises. Honours GATE_CHK_STOP_ON_FAIL_EN.
// -----------------------------------------------------------------------------
module tb_gate_response_checker;

   typedef struct {
      int cycles;
      int err;
      int mask;
      int pass;
      int in1;
      int in2;
   } exp_t;

   typedef struct {
      logic [31:0] done;
      logic [31:0] busy;
      logic [31:0] pass;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [31:0] err;
      logic [31:0] mask;
   } obs_t;

`ifdef GATE_CHK_STOP_ON_FAIL_EN
   localparam bit STOP_MODE = 1'b1;
`else
   localparam bit STOP_MODE = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] sa0;
   logic [7:0] sa1;
   logic [7:0] inv;
   int         errors;
   int         checks;
   exp_t       sb_q[$];
   exp_t       last_exp;

   gate_response_checker_if #(.ERR_W(4)) if0 ();
   gate_response_checker_if #(.ERR_W(3)) if1 ();

   gate_response_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(4)) u0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0)
   );

   gate_response_checker #(.SETTLE_CYCLES(1), .LOOPS(3), .ERR_W(3)) u1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   // Reference truth table, bit order and/or/not/nand/nor/xor/xnor/buf.
   function automatic logic [7:0] ref_gates(input logic a, input logic b);
      logic [7:0] r;
      r[0] = a & b;
      r[1] = a | b;
      r[2] = !a;
      r[3] = !(a & b);
      r[4] = !(a | b);
      r[5] = a ^ b;
      r[6] = !(a ^ b);
      r[7] = a;
      return r;
   endfunction

   assign if0.dut_out = ((ref_gates(if0.in1, if0.in2) & ~sa0) | sa1) ^ inv;
   assign if1.dut_out = ((ref_gates(if1.in1, if1.in2) & ~sa0) | sa1) ^ inv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t predict(input int loops, input int settle, input int errw,
                                    input logic [7:0] s0, input logic [7:0] s1,
                                    input logic [7:0] iv);
      exp_t       e;
      int         maxe;
      bit         stopped;
      logic [1:0] v;
      logic [7:0] good;
      logic [7:0] bad;
      logic [7:0] m;
      maxe     = (1 << errw) - 1;
      e.cycles = 0;
      e.err    = 0;
      e.mask   = 0;
      e.in1    = 0;
      e.in2    = 0;
      stopped  = 1'b0;
      for (int l = 0; l < loops; l++) begin
         for (int k = 0; k < 4; k++) begin
            if (!stopped) begin
               v        = k[1:0];
               e.cycles = e.cycles + settle + 2;
               e.in1    = int'(v[1]);
               e.in2    = int'(v[0]);
               good     = ref_gates(v[1], v[0]);
               bad      = ((good & ~s0) | s1) ^ iv;
               m        = good ^ bad;
               if (m != 8'h00) begin
                  if (e.err < maxe) e.err = e.err + 1;
                  e.mask = int'(m);
                  if (STOP_MODE) stopped = 1'b1;
               end
            end
         end
      end
      e.pass = (e.err == 0) ? 1 : 0;
      return e;
   endfunction

   function automatic obs_t get_obs(input int w);
      obs_t o;
      if (w == 0) begin
         o.done = 32'(if0.done); o.busy = 32'(if0.busy); o.pass = 32'(if0.pass);
         o.in1  = 32'(if0.in1);  o.in2  = 32'(if0.in2);
         o.err  = 32'(if0.err_count); o.mask = 32'(if0.last_mask);
      end else begin
         o.done = 32'(if1.done); o.busy = 32'(if1.busy); o.pass = 32'(if1.pass);
         o.in1  = 32'(if1.in1);  o.in2  = 32'(if1.in2);
         o.err  = 32'(if1.err_count); o.mask = 32'(if1.last_mask);
      end
      return o;
   endfunction

   task automatic set_start(input int w, input logic v);
      if (w == 0) if0.start = v;
      else        if1.start = v;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input int w, input string tag);
      obs_t o;
      o = get_obs(w);
      check({tag, ".in1"},  o.in1,  32'd0);
      check({tag, ".in2"},  o.in2,  32'd0);
      check({tag, ".busy"}, o.busy, 32'd0);
      check({tag, ".done"}, o.done, 32'd0);
      check({tag, ".pass"}, o.pass, 32'd0);
      check({tag, ".err"},  o.err,  32'd0);
      check({tag, ".mask"}, o.mask, 32'd0);
   endtask

   // One run on instance w; an extra start pulse is sampled at edge extra+1
   // (extra < 0 disables it). Cycles are counted from the accepting edge.
   task automatic run(input int w, input int extra, input string tag);
      exp_t e;
      obs_t o;
      int   n;
      if (w == 0) sb_q.push_back(predict(1, 2, 4, sa0, sa1, inv));
      else        sb_q.push_back(predict(3, 1, 3, sa0, sa1, inv));
      @(negedge clk);
      set_start(w, 1'b1);
      @(posedge clk);
      #1;
      set_start(w, 1'b0);
      o = get_obs(w);
      check({tag, ".busy_after_start"}, o.busy, 32'd1);
      check({tag, ".done_cleared"},     o.done, 32'd0);
      n = 0;
      o = get_obs(w);
      while (o.done != 32'd1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         set_start(w, (n == extra));
         o = get_obs(w);
      end
      set_start(w, 1'b0);
      e = sb_q.pop_front();
      last_exp = e;
      check({tag, ".cycles"}, 32'(n),      32'(e.cycles));
      check({tag, ".done"},   o.done,      32'd1);
      check({tag, ".busy"},   o.busy,      32'd0);
      check({tag, ".pass"},   o.pass,      32'(e.pass));
      check({tag, ".err"},    o.err,       32'(e.err));
      check({tag, ".mask"},   o.mask,      32'(e.mask));
      check({tag, ".in1"},    o.in1,       32'(e.in1));
      check({tag, ".in2"},    o.in2,       32'(e.in2));
   endtask

   task automatic set_fault(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] iv);
      sa0 = s0;
      sa1 = s1;
      inv = iv;
   endtask

   initial begin
      obs_t o;
      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      if0.start = 1'b0;
      if1.start = 1'b0;
      set_fault(8'h00, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      check_idle(0, "rst0");
      check_idle(1, "rst1");
      @(negedge clk);
      rst_n = 1'b1;

      // Clean bank, started from IDLE.
      run(0, -1, "clean");
      // xor stuck at 0: vectors 01 and 10 fail.
      set_fault(8'h20, 8'h00, 8'h00);
      run(0, -1, "xor_sa0");
      // and stuck at 1: 00/01/10 fail (stop mode: first vector only).
      set_fault(8'h00, 8'h01, 8'h00);
      run(0, -1, "and_sa1");
      // not and buf inverted: every vector fails with mask 84.
      set_fault(8'h00, 8'h00, 8'h84);
      run(0, -1, "notbuf_inv");
      // Clean rerun from DONE with a start pulse while busy.
      set_fault(8'h00, 8'h00, 8'h00);
      run(0, 7, "busy_start");
      // start coincident with the final CHECK is dropped.
      set_fault(8'h20, 8'h00, 8'h00);
      run(0, 15, "start_at_last");
      repeat (3) @(posedge clk);
      #1;
      o = get_obs(0);
      check("start_at_last.done_held", o.done, 32'd1);
      check("start_at_last.err_held",  o.err,  32'(last_exp.err));

      // Reset in the middle of a failing run.
      set_fault(8'h00, 8'h01, 8'h00);
      @(negedge clk);
      if0.start = 1'b1;
      @(posedge clk);
      #1;
      if0.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      o = get_obs(0);
      check("midrun.err_before_reset", o.err, 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle(0, "midrun_rst");
      @(negedge clk);
      rst_n = 1'b1;
      set_fault(8'h00, 8'h00, 8'h00);
      run(0, -1, "after_reset");

      // Three-loop instance: nand inverted saturates the 3-bit counter.
      set_fault(8'h00, 8'h00, 8'h08);
      run(1, -1, "u1_nand_inv");
      set_fault(8'h00, 8'h00, 8'h00);
      run(1, -1, "u1_clean");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
